// File: rtl/stage4_flatten_buffer_if.sv
// rtl/stage4_flatten_buffer_if.sv - pooled-vector input and flattened element stream bundle
interface stage4_flatten_buffer_if #(
  parameter int CH      = 3,
  parameter int NUM_POS = 16,
  parameter int IN_BW   = 32,
  parameter int OUT_BW  = 16,
  parameter int IDX_W   = $clog2(CH * NUM_POS)
);
  logic                     i_pool_valid;
  logic [CH*IN_BW-1:0]      i_pool_data;
  logic                     o_valid;
  logic                     i_ready;
  logic signed [OUT_BW-1:0] o_data;
  logic [IDX_W-1:0]         o_index;
  logic                     o_last;

  // master is the flatten buffer itself; slave is the pooling/FC environment
  modport master (
    input  i_pool_valid, i_pool_data, i_ready,
    output o_valid, o_data, o_index, o_last
  );

  modport slave (
    output i_pool_valid, i_pool_data, i_ready,
    input  o_valid, o_data, o_index, o_last
  );
endinterface

// File: rtl/stage4_flatten_buffer.sv
// rtl/stage4_flatten_buffer.sv - frame collector and channel-major flatten streamer (option: STAGE4_FLATTEN_SAT_EN)
module stage4_flatten_buffer #(
  parameter int CH      = 3,
  parameter int NUM_POS = 16,
  parameter int IN_BW   = 32,
  parameter int OUT_BW  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_clear,
  stage4_flatten_buffer_if.master   bus,
  output logic                      o_busy,
  output logic                      o_overflow
);
  localparam int IDX_W = $clog2(CH * NUM_POS);
  localparam int PW    = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int RW    = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {S_COLLECT, S_STREAM} state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            wp_q, wp_d;
  logic [RW-1:0]            rc_q, rc_d;
  logic [PW-1:0]            rp_q, rp_d;
  logic                     ovf_q, ovf_d;
  logic signed [IN_BW-1:0]  mem_q [CH][NUM_POS];
  logic signed [IN_BW-1:0]  mem_d [CH][NUM_POS];

  logic                     streaming;
  logic                     xfer;
  logic [IDX_W-1:0]         idx;
  logic                     last;

  // Narrow a pooled element to the FC width: saturate or wrap depending on build
  function automatic logic signed [OUT_BW-1:0] narrow(input logic signed [IN_BW-1:0] v);
`ifdef STAGE4_FLATTEN_SAT_EN
    logic [IN_BW-OUT_BW:0] top;
    top = v[IN_BW-1:OUT_BW-1];
    if ((&top) || !(|top))
      narrow = v[OUT_BW-1:0];
    else if (v[IN_BW-1])
      narrow = {1'b1, {(OUT_BW-1){1'b0}}};
    else
      narrow = {1'b0, {(OUT_BW-1){1'b1}}};
`else
    narrow = OUT_BW'(v);
`endif
  endfunction

  // Flatten index and transfer qualifiers, all from registered state except i_ready
  always_comb begin
    streaming = (state_q == S_STREAM);
    xfer      = streaming && bus.i_ready;
    idx       = IDX_W'(rc_q) * IDX_W'(NUM_POS) + IDX_W'(rp_q);
    last      = (idx == IDX_W'(CH * NUM_POS - 1));
  end

  // State, pointers, sticky overflow and buffer; reset also zeroes the buffer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_COLLECT;
      wp_q    <= '0;
      rc_q    <= '0;
      rp_q    <= '0;
      ovf_q   <= 1'b0;
      for (int c = 0; c < CH; c++)
        for (int p = 0; p < NUM_POS; p++)
          mem_q[c][p] <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rc_q    <= rc_d;
      rp_q    <= rp_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

  // Next state: frame complete enters STREAM, the o_last transfer returns to COLLECT
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = S_COLLECT;
    end else begin
      case (state_q)
        S_COLLECT: if (bus.i_pool_valid && wp_q == PW'(NUM_POS - 1)) state_d = S_STREAM;
        S_STREAM:  if (xfer && last) state_d = S_COLLECT;
        default:   state_d = S_COLLECT;
      endcase
    end
  end

  // Datapath: capture vectors in COLLECT, walk rc/rp in STREAM, flag dropped vectors
  always_comb begin
    wp_d  = wp_q;
    rc_d  = rc_q;
    rp_d  = rp_q;
    ovf_d = ovf_q;
    mem_d = mem_q;
    if (i_clear) begin
      wp_d  = '0;
      rc_d  = '0;
      rp_d  = '0;
      ovf_d = 1'b0;
    end else if (state_q == S_COLLECT) begin
      if (bus.i_pool_valid) begin
        for (int c = 0; c < CH; c++)
          mem_d[c][wp_q] = bus.i_pool_data[c*IN_BW +: IN_BW];
        wp_d = (wp_q == PW'(NUM_POS - 1)) ? '0 : wp_q + PW'(1);
      end
    end else begin
      if (bus.i_pool_valid) ovf_d = 1'b1;
      if (xfer) begin
        if (last) begin
          rc_d = '0;
          rp_d = '0;
        end else if (rp_q == PW'(NUM_POS - 1)) begin
          rp_d = '0;
          rc_d = rc_q + RW'(1);
        end else begin
          rp_d = rp_q + PW'(1);
        end
      end
    end
  end

  // Outputs: stream fields are forced to zero outside STREAM
  always_comb begin
    bus.o_valid = streaming;
    bus.o_data  = streaming ? narrow(mem_q[rc_q][rp_q]) : '0;
    bus.o_index = streaming ? idx : '0;
    bus.o_last  = streaming && last;
    o_busy      = streaming;
    o_overflow  = ovf_q;
  end
endmodule

// File: tb/tb_stage4_flatten_buffer.sv
// tb/tb_stage4_flatten_buffer.sv - scoreboard bench for the flatten buffer
module tb_stage4_flatten_buffer;
  localparam int CH = 3, NUM_POS = 16, IN_BW = 32, OUT_BW = 16, IDX_W = 6, N = 48;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_clear = 1'b0;
  logic o_busy, o_overflow;

  stage4_flatten_buffer_if #(.CH(CH), .NUM_POS(NUM_POS), .IN_BW(IN_BW), .OUT_BW(OUT_BW)) bus ();

  stage4_flatten_buffer #(.CH(CH), .NUM_POS(NUM_POS), .IN_BW(IN_BW), .OUT_BW(OUT_BW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (i_clear),
    .bus        (bus.master),
    .o_busy     (o_busy),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [OUT_BW-1:0] d;
    logic [IDX_W-1:0]         idx;
    logic                     last;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold stability under backpressure
  logic                     held_v = 1'b0;
  logic signed [OUT_BW-1:0] held_d;
  logic [IDX_W-1:0]         held_i;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && bus.o_valid) begin
        if (held_v) begin
          chk("hold_data", longint'(bus.o_data), longint'(held_d));
          chk("hold_index", longint'(bus.o_index), longint'(held_i));
        end
        if (bus.i_ready) begin
          held_v = 1'b0;
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_xfer actual_index=%0d required=none", bus.o_index);
          end else begin
            e = sbq.pop_front();
            chk("xfer_data", longint'(bus.o_data), longint'(e.d));
            chk("xfer_index", longint'(bus.o_index), longint'(e.idx));
            chk("xfer_last", longint'(bus.o_last), longint'(e.last));
          end
        end else begin
          held_v = 1'b1;
          held_d = bus.o_data;
          held_i = bus.o_index;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  // Drive nvec vectors back to back; element (c,p) = base + 100*c + p, sat frame overrides two
  task automatic send_frame(input int base, input bit sat, input int nvec, input bit push);
    logic [CH*IN_BW-1:0] v;
    int val;
    exp_t e;
    bus.i_ready = 1'b0;
    if (push) begin
      for (int c = 0; c < CH; c++)
        for (int p = 0; p < NUM_POS; p++) begin
          e.d = OUT_BW'(base + 100 * c + p);
          if (sat && c == 1 && p == 2) begin
`ifdef STAGE4_FLATTEN_SAT_EN
            e.d = 16'sd32767;
`else
            e.d = -16'sd25536;
`endif
          end
          if (sat && c == 2 && p == 3) begin
`ifdef STAGE4_FLATTEN_SAT_EN
            e.d = -16'sd32768;
`else
            e.d = 16'sd25536;
`endif
          end
          e.idx  = IDX_W'(c * NUM_POS + p);
          e.last = (c * NUM_POS + p == N - 1);
          sbq.push_back(e);
        end
    end
    for (int p = 0; p < nvec; p++) begin
      for (int c = 0; c < CH; c++) begin
        val = base + 100 * c + p;
        if (sat && c == 1 && p == 2) val = 40000;
        if (sat && c == 2 && p == 3) val = -40000;
        v[c*IN_BW +: IN_BW] = val;
      end
      bus.i_pool_valid = 1'b1;
      bus.i_pool_data  = v;
      if (p < nvec - 1) begin
        @(posedge clk);
        #1;
      end
    end
    if (nvec == NUM_POS) begin
      @(negedge clk);
      chk("valid_before_last_capture", longint'(bus.o_valid), 0);
      @(posedge clk);
      #1;
      bus.i_pool_valid = 1'b0;
      @(negedge clk);
      chk("valid_after_last_capture", longint'(bus.o_valid), 1);
      chk("busy_in_stream", longint'(o_busy), 1);
      chk("first_index", longint'(bus.o_index), 0);
    end
    @(posedge clk);
    #1;
    bus.i_pool_valid = 1'b0;
  endtask

  // Consume stop_after transfers; mode 1 toggles ready 1,0,0,1; optional dropped-vector pulses
  task automatic stream(input int stop_after, input bit mode, input int ovf_a, input int ovf_b,
                        output int cycles);
    bit [3:0] pat;
    int x, cyc, ph;
    bit done_a, done_b;
    pat = 4'b1001;
    x = 0; cyc = 0; ph = 0; done_a = 0; done_b = 0;
    while (x < stop_after && cyc < 400) begin
      bus.i_ready = mode ? pat[ph % 4] : 1'b1;
      ph++;
      bus.i_pool_valid = 1'b0;
      if ((x == ovf_a && !done_a) || (x == ovf_b && !done_b)) begin
        if (x == ovf_a) done_a = 1; else done_b = 1;
        bus.i_pool_valid = 1'b1;
        bus.i_pool_data  = {CH{32'h0000_7777}};
      end
      @(negedge clk);
      if (bus.o_valid && bus.i_ready) x++;
      cyc++;
      @(posedge clk);
      #1;
    end
    bus.i_pool_valid = 1'b0;
    bus.i_ready = 1'b0;
    if (x < stop_after) begin
      total++;
      bad++;
      $display("FAIL stream_timeout actual=%0d required=%0d", x, stop_after);
    end
    cycles = cyc;
  endtask

  task automatic after_frame();
    @(negedge clk);
    chk("busy_after_last", longint'(o_busy), 0);
    chk("valid_after_last", longint'(bus.o_valid), 0);
    chk("scoreboard_drained", longint'(sbq.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    bus.i_pool_valid = 1'b0;
    bus.i_pool_data  = '0;
    bus.i_ready      = 1'b0;
    #2;
    chk("rst_valid", longint'(bus.o_valid), 0);
    chk("rst_data", longint'(bus.o_data), 0);
    chk("rst_index", longint'(bus.o_index), 0);
    chk("rst_last", longint'(bus.o_last), 0);
    chk("rst_busy", longint'(o_busy), 0);
    chk("rst_overflow", longint'(o_overflow), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // basic frame, ready held high
    send_frame(0, 0, NUM_POS, 1);
    stream(N, 0, -1, -1, cyc);
    chk("stream_cycles", cyc, N);
    after_frame();

    // backpressure
    send_frame(0, 0, NUM_POS, 1);
    stream(N, 1, -1, -1, cyc);
    after_frame();

    // overflow at index 5 and on the o_last transfer
    send_frame(0, 0, NUM_POS, 1);
    stream(N, 0, 5, N - 1, cyc);
    after_frame();
    chk("overflow_set", longint'(o_overflow), 1);
    send_frame(1000, 0, NUM_POS, 1);
    chk("overflow_sticky", longint'(o_overflow), 1);
    stream(N, 0, -1, -1, cyc);
    after_frame();

    // narrowing of out-of-range elements
    send_frame(0, 1, NUM_POS, 1);
    stream(N, 0, -1, -1, cyc);
    after_frame();

    // abort after 7 vectors in COLLECT
    send_frame(500, 0, 7, 0);
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    @(negedge clk);
    chk("clear_collect_valid", longint'(bus.o_valid), 0);
    chk("clear_collect_overflow", longint'(o_overflow), 0);
    @(posedge clk);
    #1;
    send_frame(2000, 0, NUM_POS, 1);
    stream(N, 0, -1, -1, cyc);
    after_frame();

    // abort at index 20 in STREAM
    send_frame(3000, 0, NUM_POS, 1);
    stream(20, 0, 3, -1, cyc);
    chk("overflow_before_clear", longint'(o_overflow), 1);
    chk("index_before_clear", longint'(bus.o_index), 20);
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    sbq.delete();
    @(negedge clk);
    chk("clear_stream_valid", longint'(bus.o_valid), 0);
    chk("clear_stream_overflow", longint'(o_overflow), 0);
    @(posedge clk);
    #1;
    send_frame(4000, 0, NUM_POS, 1);
    stream(N, 0, -1, -1, cyc);
    after_frame();

    // asynchronous reset at index 30, away from any clock edge
    send_frame(5000, 0, NUM_POS, 1);
    stream(30, 0, 7, -1, cyc);
    chk("index_before_reset", longint'(bus.o_index), 30);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", longint'(bus.o_valid), 0);
    chk("arst_data", longint'(bus.o_data), 0);
    chk("arst_index", longint'(bus.o_index), 0);
    chk("arst_last", longint'(bus.o_last), 0);
    chk("arst_busy", longint'(o_busy), 0);
    chk("arst_overflow", longint'(o_overflow), 0);
    sbq.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_frame(6000, 0, NUM_POS, 1);
    stream(N, 0, -1, -1, cyc);
    chk("stream_cycles_after_reset", cyc, N);
    after_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
